odyssey_video_out: RTL

- Downstream of the Odyssey core, upstream of the framework video outputs.
- Takes the core's raw HSync/VSync and 8-bit luma, measures line and frame timing, and generates HBlank/VBlank/DE.
- Applies the OSD noise-colour select and delivers aligned RGB plus sync.
- Replaces the ad-hoc blank counter in the emu top and adds timing measurement and a sync-lost indication.

---
 rtl/odyssey_video_out_if.sv | 34 +++
 rtl/odyssey_video_out.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/odyssey_video_out_if.sv
// Video path bundle between the Odyssey core and the framework outputs.
// The master side drives raw sync/luma and controls; the slave returns timed video.
interface odyssey_video_out_if #(
    parameter int unsigned CNT_W = 12
);
    logic             pal;
    logic [1:0]       col;
    logic             hsync_in;
    logic             vsync_in;
    logic [7:0]       video_in;
    logic             hsync_out;
    logic             vsync_out;
    logic             hblank;
    logic             vblank;
    logic             de;
    logic [7:0]       r;
    logic [7:0]       g;
    logic [7:0]       b;
    logic [CNT_W-1:0] line_len;
    logic [CNT_W-1:0] frame_lines;
    logic             sync_ok;

    modport master (
        output pal, col, hsync_in, vsync_in, video_in,
        input  hsync_out, vsync_out, hblank, vblank, de, r, g, b,
               line_len, frame_lines, sync_ok
    );

    modport slave (
        input  pal, col, hsync_in, vsync_in, video_in,
        output hsync_out, vsync_out, hblank, vblank, de, r, g, b,
               line_len, frame_lines, sync_ok
    );
endinterface

// File: rtl/odyssey_video_out.sv
// Odyssey video back end: measures line/frame timing from raw syncs, derives
// blanking/DE, colours the luma and emits RGB + sync with a fixed 3-clock latency.
module odyssey_video_out #(
    parameter int unsigned H_ACT_START    = 88,
    parameter int unsigned H_ACT_END      = 1147,
    parameter int unsigned V_ACT_START    = 34,
    parameter int unsigned V_ACT_END_NTSC = 240,
    parameter int unsigned V_ACT_END_PAL  = 288,
    parameter int unsigned CNT_W          = 12,
    parameter int unsigned LEN_TOL        = 2
) (
    input logic                clk,
    input logic                reset,
    odyssey_video_out_if.slave vio
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == CNT_MAX) ? x : x + CNT_W'(1);
    endfunction

    logic             hs0_q, hs1_q, vs0_q, vs1_q, vs_l_q, vs_l_d;
    logic             hsync_out_q, vsync_out_q;
    logic [7:0]       v0_q, vd_q;
    logic [7:0]       r_q, r_d, g_q, g_d, b_q, b_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [CNT_W-1:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
    logic             pal_l_q, pal_l_d;
    logic             hblank_q, hblank_d, vblank_q, vblank_d, de_q, de_d;
    logic             sync_ok_q, sync_ok_d;
    logic             hfall, vfall;
    logic [CNT_W:0]   hlen, len_diff;
    logic [CNT_W-1:0] v_end;

    assign hfall = hs1_q & ~hs0_q;
    // VSync is only looked at on line starts, so a frame begins on the first low line
    assign vfall = vs_l_q & ~vs0_q;
    // Unsaturated length keeps a saturated line from looking in-tolerance
    assign hlen     = {1'b0, hcnt_q} + (CNT_W+1)'(1);
    assign len_diff = (hlen >= {1'b0, line_len_q}) ? hlen - {1'b0, line_len_q}
                                                   : {1'b0, line_len_q} - hlen;
    assign v_end    = pal_l_q ? CNT_W'(V_ACT_END_PAL) : CNT_W'(V_ACT_END_NTSC);

    always_comb begin
        hcnt_d        = hfall ? '0 : sat_inc(hcnt_q);
        line_len_d    = hfall ? sat_inc(hcnt_q) : line_len_q;
        vcnt_d        = vcnt_q;
        frame_lines_d = frame_lines_q;
        pal_l_d       = pal_l_q;
        vs_l_d        = vs_l_q;
        sync_ok_d     = sync_ok_q;

        if (hfall) begin
            vs_l_d = vs0_q;
            if (vfall) begin
                vcnt_d        = '0;
                frame_lines_d = sat_inc(vcnt_q);
                pal_l_d       = vio.pal;
            end else begin
                vcnt_d = sat_inc(vcnt_q);
            end
        end

        if (hcnt_q == CNT_MAX) begin
            sync_ok_d = 1'b0;
        end else if (hfall) begin
            if (len_diff > (CNT_W+1)'(LEN_TOL))
                sync_ok_d = 1'b0;
            else if (line_len_q != '0)
                sync_ok_d = 1'b1;
        end

        // End compare comes last so it wins when start == end
        hblank_d = hblank_q;
        if (hcnt_q == CNT_W'(H_ACT_START)) hblank_d = 1'b0;
        if (hcnt_q == CNT_W'(H_ACT_END))   hblank_d = 1'b1;
        vblank_d = vblank_q;
        if (vcnt_q == CNT_W'(V_ACT_START)) vblank_d = 1'b0;
        if (vcnt_q == v_end)               vblank_d = 1'b1;

        // DE and RGB share the blanking cycle so all outputs line up
        de_d = ~(hblank_d | vblank_d);
        r_d  = (de_d && (vio.col == 2'd0 || vio.col == 2'd1)) ? vd_q : 8'h00;
        g_d  = (de_d && (vio.col == 2'd0 || vio.col == 2'd2)) ? vd_q : 8'h00;
        b_d  = (de_d && (vio.col == 2'd0 || vio.col == 2'd3)) ? vd_q : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs0_q         <= 1'b1;
            hs1_q         <= 1'b1;
            vs0_q         <= 1'b1;
            vs1_q         <= 1'b1;
            vs_l_q        <= 1'b1;
            hsync_out_q   <= 1'b1;
            vsync_out_q   <= 1'b1;
            v0_q          <= 8'h00;
            vd_q          <= 8'h00;
            r_q           <= 8'h00;
            g_q           <= 8'h00;
            b_q           <= 8'h00;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            pal_l_q       <= 1'b0;
            hblank_q      <= 1'b1;
            vblank_q      <= 1'b1;
            de_q          <= 1'b0;
            sync_ok_q     <= 1'b0;
        end else begin
            hs0_q         <= vio.hsync_in;
            hs1_q         <= hs0_q;
            vs0_q         <= vio.vsync_in;
            vs1_q         <= vs0_q;
            vs_l_q        <= vs_l_d;
            hsync_out_q   <= hs1_q;
            vsync_out_q   <= vs1_q;
            v0_q          <= vio.video_in;
            vd_q          <= v0_q;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            pal_l_q       <= pal_l_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            de_q          <= de_d;
            sync_ok_q     <= sync_ok_d;
        end
    end

    assign vio.hsync_out   = hsync_out_q;
    assign vio.vsync_out   = vsync_out_q;
    assign vio.hblank      = hblank_q;
    assign vio.vblank      = vblank_q;
    assign vio.de          = de_q;
    assign vio.r           = r_q;
    assign vio.g           = g_q;
    assign vio.b           = b_q;
    assign vio.line_len    = line_len_q;
    assign vio.frame_lines = frame_lines_q;
    assign vio.sync_ok     = sync_ok_q;
endmodule
